// File: rtl/apb_stream_fifo.sv
// APB3 slave bridging a TX FIFO (APB write -> M_ stream) and an RX FIFO (S_ stream -> APB read).
// Zero-wait APB; streams are FWFT with ready/valid backpressure; IRQ lags its sources by one cycle.
module apb_stream_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic [31:0]       PADDR,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              M_TVALID,
    output logic [DATA_W-1:0] M_TDATA,
    input  logic              M_TREADY,
    input  logic              S_TVALID,
    input  logic [DATA_W-1:0] S_TDATA,
    output logic              S_TREADY,
    output logic              IRQ
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Index 0 is the TX FIFO, index 1 the RX FIFO.
    logic              fifo_push  [2];
    logic              fifo_pop   [2];
    logic              fifo_flush [2];
    logic [DATA_W-1:0] fifo_wdata [2];
    logic [DATA_W-1:0] fifo_head  [2];
    logic              fifo_empty [2];
    logic              fifo_full  [2];
    logic [CW-1:0]     fifo_count [2];

    for (genvar f = 0; f < 2; f++) begin : g_fifo
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]     count_q, count_d;
        logic              do_push, do_pop;

        assign fifo_empty[f] = (count_q == '0);
        assign fifo_full[f]  = (count_q == CNT_FULL);
        assign fifo_count[f] = count_q;
        assign fifo_head[f]  = mem_q[rd_ptr_q];
        assign do_push       = fifo_push[f] & ~fifo_full[f];
        assign do_pop        = fifo_pop[f] & ~fifo_empty[f];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (fifo_flush[f]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
                else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
            end
        end

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        always_ff @(posedge PCLK) begin
            if (do_push && !fifo_flush[f]) mem_q[wr_ptr_q] <= fifo_wdata[f];
        end
    end

    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic              irq_en_q, irq_en_d, irq_q, irq_d;
    logic              apb_setup, apb_access;
    logic [1:0]        reg_sel;
    logic              wr_data, rd_data, ctrl_wr;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              clr_err;
    logic [31:0]       status;
    logic              unused_paddr;

    assign unused_paddr = ^{PADDR[31:4], PADDR[1:0]};
    assign reg_sel      = PADDR[3:2];
    assign apb_setup    = PSEL & ~PENABLE;
    assign apb_access   = PSEL & PENABLE;
    assign wr_data      = apb_access & PWRITE & (reg_sel == 2'd0);
    assign rd_data      = apb_access & ~PWRITE & (reg_sel == 2'd0);
    assign ctrl_wr      = apb_access & PWRITE & (reg_sel == 2'd2);

    // The error verdict latched at setup also gates the access-phase push/pop.
    assign tx_push  = wr_data & ~pslverr_q;
    assign rx_pop   = rd_data & ~pslverr_q;
    assign tx_pop   = M_TVALID & M_TREADY;
    assign rx_push  = S_TVALID & S_TREADY;
    assign clr_err  = ctrl_wr & PWDATA[2];

    assign fifo_push[0]  = tx_push;
    assign fifo_pop[0]   = tx_pop;
    assign fifo_flush[0] = ctrl_wr & PWDATA[0];
    assign fifo_wdata[0] = PWDATA;
    assign fifo_push[1]  = rx_push;
    assign fifo_pop[1]   = rx_pop;
    assign fifo_flush[1] = ctrl_wr & PWDATA[1];
    assign fifo_wdata[1] = S_TDATA;

    assign status = {8'h00, 8'(fifo_count[1]), 8'(fifo_count[0]), 2'b00,
                     rx_udf_q, tx_ovf_q, fifo_full[1], fifo_empty[1],
                     fifo_full[0], fifo_empty[0]};

    always_comb begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (apb_setup) begin
            case (reg_sel)
                2'd0: begin
                    if (PWRITE) begin
                        pslverr_d = fifo_full[0];
                    end else begin
                        pslverr_d = fifo_empty[1];
                        prdata_d  = fifo_empty[1] ? '0 : fifo_head[1];
                    end
                end
                2'd1:    if (!PWRITE) prdata_d = status;
                2'd2:    if (!PWRITE) prdata_d = {{(DATA_W-4){1'b0}}, irq_en_q, 3'b000};
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_ovf_d = tx_ovf_q | (wr_data & pslverr_q);
        rx_udf_d = rx_udf_q | (rd_data & pslverr_q);
        if (clr_err) begin
            tx_ovf_d = 1'b0;
            rx_udf_d = 1'b0;
        end
        irq_en_d = ctrl_wr ? PWDATA[3] : irq_en_q;
        irq_d    = irq_en_q & (~fifo_empty[1] | tx_ovf_q | rx_udf_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_udf_q  <= rx_udf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PSLVERR  = pslverr_q;
    assign PREADY   = 1'b1;
    assign M_TVALID = ~fifo_empty[0];
    assign M_TDATA  = fifo_head[0];
    assign S_TREADY = ~fifo_full[1];
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_apb_stream_fifo.sv
// Bench for apb_stream_fifo: queue-based reference model checked every cycle,
// plus directed APB/stream sequences with literal expectations.
module tb_apb_stream_fifo;
    localparam int DEPTH = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        M_TVALID, M_TREADY = 1'b0;
    logic [31:0] M_TDATA;
    logic        S_TVALID = 1'b0, S_TREADY;
    logic [31:0] S_TDATA = '0;
    logic        IRQ;

    apb_stream_fifo #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .M_TVALID(M_TVALID), .M_TDATA(M_TDATA),
        .M_TREADY(M_TREADY), .S_TVALID(S_TVALID), .S_TDATA(S_TDATA),
        .S_TREADY(S_TREADY), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, registers as plain flags.
    logic [31:0] m_tx[$], m_rx[$], tx_log[$];
    bit          m_ovf, m_udf, m_irq_en, m_irq, m_setup_err, m_pslverr;
    logic [31:0] m_prdata = '0;
    int          m_tsz, m_rsz;
    bit          acc, setp, tpop, rpush, tflush, rflush, clr, nirq, ne;
    logic [1:0]  ma;
    logic [31:0] np;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_tx.delete(); m_rx.delete();
            m_ovf = 0; m_udf = 0; m_irq_en = 0; m_irq = 0;
            m_setup_err = 0; m_pslverr = 0; m_prdata = '0;
        end else begin
            m_tsz = m_tx.size(); m_rsz = m_rx.size();
            acc = PSEL && PENABLE; setp = PSEL && !PENABLE; ma = PADDR[3:2];
            nirq  = m_irq_en && (m_rsz != 0 || m_ovf || m_udf);
            tpop  = (m_tsz != 0) && M_TREADY;
            rpush = (m_rsz < DEPTH) && S_TVALID;
            np = '0; ne = 0;
            if (setp) begin
                case (ma)
                    2'd0: if (PWRITE) ne = (m_tsz == DEPTH);
                          else begin ne = (m_rsz == 0); np = ne ? 32'h0 : m_rx[0]; end
                    2'd1: if (!PWRITE)
                              np = (m_tsz == 0 ? 32'h1 : 0) | (m_tsz == DEPTH ? 32'h2 : 0)
                                 | (m_rsz == 0 ? 32'h4 : 0) | (m_rsz == DEPTH ? 32'h8 : 0)
                                 | (m_ovf ? 32'h10 : 0) | (m_udf ? 32'h20 : 0)
                                 | (m_tsz * 256) | (m_rsz * 65536);
                    2'd2: if (!PWRITE) np = m_irq_en ? 32'h8 : 32'h0;
                    default: ;
                endcase
            end
            tflush = 0; rflush = 0; clr = 0;
            if (acc && PWRITE && ma == 2'd2) begin
                tflush = PWDATA[0]; rflush = PWDATA[1]; clr = PWDATA[2]; m_irq_en = PWDATA[3];
            end
            if (tflush) m_tx.delete();
            else begin
                if (tpop) tx_log.push_back(m_tx.pop_front());
                if (acc && PWRITE && ma == 2'd0 && !m_setup_err) m_tx.push_back(PWDATA);
            end
            if (acc && PWRITE && ma == 2'd0 && m_setup_err) m_ovf = 1;
            if (rflush) m_rx.delete();
            else begin
                if (acc && !PWRITE && ma == 2'd0 && !m_setup_err) void'(m_rx.pop_front());
                if (rpush) m_rx.push_back(S_TDATA);
            end
            if (acc && !PWRITE && ma == 2'd0 && m_setup_err) m_udf = 1;
            if (clr) begin m_ovf = 0; m_udf = 0; end
            if (setp) m_setup_err = ne;
            m_prdata = np; m_pslverr = ne; m_irq = nirq;
        end
    end

    always @(negedge PCLK) begin
        chk("M_TVALID", M_TVALID, m_tx.size() != 0);
        if (m_tx.size() != 0) chk("M_TDATA", M_TDATA, m_tx[0]);
        chk("S_TREADY", S_TREADY, m_rx.size() < DEPTH);
        chk("IRQ", IRQ, m_irq);
        chk("PRDATA", PRDATA, m_prdata);
        chk("PSLVERR", PSLVERR, m_pslverr);
        chk("PREADY", PREADY, 1'b1);
    end

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = addr; PWDATA = data;
        @(negedge PCLK); PENABLE = 1; err = PSLVERR;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = addr;
        @(negedge PCLK); PENABLE = 1; data = PRDATA; err = PSLVERR;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge PCLK); PSEL = 0; PENABLE = 0; end
    endtask

    task automatic chk_log(input string name, input int n, input logic [31:0] base);
        chk({name, "_len"}, tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++) chk(name, tx_log[i], base + i);
    endtask

    logic [31:0] rd;
    logic        err;

    initial begin
        repeat (3) @(negedge PCLK);
        PRESETn = 1;
        tick(1);
        apb_read(32'h4, rd, err); chk("status_reset", rd, 32'h0000_0005);

        // Three words held back, then drained in order.
        M_TREADY = 0; tx_log.delete();
        for (int i = 1; i <= 3; i++) begin apb_write(32'h0, 32'hA5A5_0000 + i, err); chk("wr_err", err, 0); end
        tick(1);
        apb_read(32'h4, rd, err); chk("status_tx3", rd, 32'h0000_0304);
        chk("m_tvalid_lit", M_TVALID, 1); chk("m_tdata_lit", M_TDATA, 32'hA5A5_0001);
        tick(1); M_TREADY = 1; tick(5);
        chk_log("drain3", 3, 32'hA5A5_0001);
        chk("m_tvalid_end", M_TVALID, 0);

        // TX overflow.
        M_TREADY = 0; tx_log.delete();
        for (int i = 0; i < 16; i++) apb_write(32'h0, 32'h1000 + i, err);
        apb_write(32'h0, 32'hDEAD_BEEF, err); chk("ovf_err", err, 1);
        tick(1);
        apb_read(32'h4, rd, err); chk("status_ovf", rd, 32'h0000_1016);
        tick(1); M_TREADY = 1; tick(20);
        chk_log("drain16", 16, 32'h1000);

        // RX fill to full, drain, underflow.
        for (int i = 1; i <= 16; i++) begin @(negedge PCLK); S_TVALID = 1; S_TDATA = i; end
        @(negedge PCLK); S_TDATA = 32'h11; chk("s_tready_full", S_TREADY, 0);
        @(negedge PCLK); S_TVALID = 0;
        apb_read(32'h4, rd, err); chk("status_rxfull", rd, 32'h0010_0019);
        for (int i = 1; i <= 16; i++) begin
            apb_read(32'h0, rd, err); chk("rx_data", rd, i); chk("rx_err", err, 0);
        end
        apb_read(32'h0, rd, err); chk("udf_err", err, 1); chk("udf_data", rd, 0);
        tick(1);
        apb_read(32'h4, rd, err); chk("status_udf", rd, 32'h0000_0035);

        // Error clear and interrupt.
        apb_write(32'h8, 32'h4, err); tick(1);
        apb_read(32'h4, rd, err); chk("status_clr", rd, 32'h0000_0005);
        apb_read(32'h8, rd, err); chk("ctrl_rd0", rd, 0);
        apb_write(32'h8, 32'h8, err);
        apb_read(32'h8, rd, err); chk("ctrl_rd8", rd, 32'h8);
        apb_write(32'hC, 32'hFFFF_FFFF, err); chk("rsvd_wr_err", err, 0);
        apb_read(32'hC, rd, err); chk("rsvd_rd", rd, 0);
        tick(2);
        @(negedge PCLK); S_TVALID = 1; S_TDATA = 32'h77;
        @(negedge PCLK); S_TVALID = 0; chk("irq_lag", IRQ, 0);
        @(negedge PCLK); chk("irq_set", IRQ, 1);
        apb_read(32'h0, rd, err); chk("irq_word", rd, 32'h77);
        tick(2); chk("irq_clr", IRQ, 0);
        apb_read(32'h0, rd, err); chk("udf2_err", err, 1);
        tick(2); chk("irq_udf", IRQ, 1);
        apb_write(32'h8, 32'hC, err);
        tick(2); chk("irq_after_clr", IRQ, 0);

        // Streaming throughput and pointer wrap.
        M_TREADY = 1; tx_log.delete();
        for (int i = 0; i < 40; i++) apb_write(32'h0, 32'h2000 + i, err);
        tick(4);
        chk_log("wrap40", 40, 32'h2000);

        // Flush colliding with a stream pop.
        M_TREADY = 0; tx_log.delete();
        for (int i = 0; i < 5; i++) apb_write(32'h0, 32'h3000 + i, err);
        M_TREADY = 1;
        apb_write(32'h8, 32'h9, err);
        tick(3);
        chk_log("flush", 2, 32'h3000);
        apb_read(32'h4, rd, err); chk("status_flush", rd, 32'h0000_0005);

        // Asynchronous reset in the middle of an access.
        tick(1); M_TREADY = 0;
        for (int i = 0; i < 8; i++) apb_write(32'h0, 32'h4000 + i, err);
        tick(1);
        for (int i = 0; i < 8; i++) begin @(negedge PCLK); S_TVALID = 1; S_TDATA = 32'h5000 + i; end
        @(negedge PCLK); S_TVALID = 0;
        tick(2); chk("irq_pre_rst", IRQ, 1);
        @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h0;
        @(negedge PCLK); PENABLE = 1; chk("prdata_pre_rst", PRDATA, 32'h5000);
        #2 PRESETn = 0;
        #1;
        chk("rst_prdata", PRDATA, 0); chk("rst_pslverr", PSLVERR, 0);
        chk("rst_m_tvalid", M_TVALID, 0); chk("rst_s_tready", S_TREADY, 1);
        chk("rst_irq", IRQ, 0);
        @(negedge PCLK); PSEL = 0; PENABLE = 0; PRESETn = 1;
        tick(1);
        apb_read(32'h4, rd, err); chk("status_post_rst", rd, 32'h0000_0005);
        apb_read(32'h8, rd, err); chk("ctrl_post_rst", rd, 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_stream_fifo.md
Name: apb_stream_fifo

Overview:
APB3 slave that links the APB bus from bfm_apb_s4 to a 32-bit valid/ready stream. It occupies one PSEL slot next to the mem_apb slaves. APB writes push words into a TX FIFO, which drains to the M_ stream. Words arriving on the S_ stream fill an RX FIFO, which APB reads pop. Status, flush and interrupt logic are memory-mapped.

Parameters:
DEPTH, 16, entries per FIFO; power of 2, 2..128.
DATA_W, 32, FIFO/stream width; fixed to APB data width.

Ports:
PCLK  in  1  clock; everything is synchronous to its rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select from decoder
PADDR  in  32  byte address; only [3:2] decoded
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer ready
PSLVERR  out  1  transfer error
M_TVALID  out  1  TX stream valid
M_TDATA  out  32  TX stream data
M_TREADY  in  1  TX stream ready
S_TVALID  in  1  RX stream valid
S_TDATA  in  32  RX stream data
S_TREADY  out  1  RX stream ready
IRQ  out  1  level interrupt, registered

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - both FIFOs emptied; sticky flags and irq_en cleared.
  - PRDATA=0, PSLVERR=0, M_TVALID=0, S_TREADY=1, IRQ=0.
  - PREADY is tied to 1.
- APB protocol:
  - No wait states: each transfer is one setup cycle plus one access cycle.
  - Transfer completes on PSEL & PENABLE (PREADY=1).
  - PRDATA/PSLVERR are registered at setup (PSEL & !PENABLE) and valid throughout the access cycle.
  - FIFO side effects occur at the access-phase edge.
  - PSLVERR=0 and PRDATA=0 outside access.
- Register map on PADDR[3:2]:
  - 0 DATA: write pushes PWDATA to TX; read pops RX head.
  - 1 STATUS (RO): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_udf, [15:8] tx_count, [23:16] rx_count; other bits 0. Writes ignored, no error.
  - 2 CONTROL: write bit0 tx_flush, bit1 rx_flush, bit2 clr_err (all write-1 pulses), bit3 irq_en (stored). Read returns {28'b0, irq_en, 3'b0}.
  - 3 reserved: reads 0, writes ignored, PSLVERR=0.
- Error cases:
  - DATA write while tx_full (sampled at setup): PSLVERR=1, word dropped, tx_ovf set.
  - DATA read while rx_empty: PSLVERR=1, PRDATA=0, rx_udf set, no pop.
- TX stream:
  - First-word-fall-through: M_TVALID = !tx_empty, M_TDATA = TX head.
  - Pop on M_TVALID & M_TREADY.
  - M_TDATA is held stable while M_TVALID is high and M_TREADY is low.
- RX stream:
  - S_TREADY = !rx_full.
  - Push S_TDATA on S_TVALID & S_TREADY.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle: count unchanged, both take effect.
  - Full/empty decisions use the pre-edge state. An APB write to a full TX FIFO errors even if the stream pops that same cycle.
  - A flush overrides any push/pop in the same cycle; the FIFO ends empty.
  - clr_err overrides a same-cycle error set; the flag ends cleared.
- Counters and pointers:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Counts are log2(DEPTH)+1 bits, zero-extended into the 8-bit STATUS fields.
- Interrupt: IRQ is registered (one-cycle latency) as irq_en & (!rx_empty | tx_ovf | rx_udf).

Test Plan:
- Write 0xA5A5_0001..0xA5A5_0003 to DATA with M_TREADY=0 -> STATUS tx_count=3, M_TVALID=1, M_TDATA=0xA5A5_0001. Raise M_TREADY -> stream emits words in order, then M_TVALID=0.
- Fill TX with 16 words (DEPTH=16, M_TREADY=0), then write 0xDEAD_BEEF -> PSLVERR=1 on that access, STATUS[4]=1, drained stream holds exactly the 16 original words.
- Drive S_ stream with 0x1..0x10 -> S_TREADY=0 after 16 words, rx_full=1. Read DATA 16 times -> PRDATA 0x1..0x10. A 17th read -> PSLVERR=1, PRDATA=0, rx_udf=1.
- Write CONTROL=0x8, push one RX word -> IRQ=1 one cycle after the push. Read DATA -> IRQ=0. Write CONTROL=0x4 after an underflow -> STATUS[5]=0.
- Continuous M_TREADY=1 with back-to-back APB writes, and a TX flush issued while a pop is occurring -> tx_count=0 after the flush and no word duplicated. Check wrap-around over 40 words.
- Assert PRESETn=0 mid-access with both FIFOs half full -> all outputs reach reset values without waiting for a PCLK edge; STATUS reads 0x0000_0005 after reset.
